affine_loop_controller: RTL and testbench
=========================================

Name: affine_loop_controller

Overview:
- Generates the iteration schedule for one compute op: loop-counter values (ctrl_vars) plus a per-iteration strobe.
- Sits directly upstream of a unified buffer. Drives that buffer's <op>_write_wen/<op>_read_ren and <op>_write_ctrl_vars/<op>_read_ctrl_vars ports, and fires the matching compute kernel.
- Walks a rectangular DIM-level loop nest after a programmable start delay, at a fixed initiation interval.

Parameters:
- WIDTH, 16, bit width of each ctrl_var and of each extent.
- DIM, 3, number of loop levels; index 0 is outermost, DIM-1 is innermost.
- EXTENTS, {1,64,64}, per-level trip count, array [DIM]; each value in 1..2^WIDTH-1.
- START_DELAY, 0, cycles between flush acceptance and the first strobe; 32-bit.
- II, 1, cycles between consecutive strobes; 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous schedule (re)start pulse.
- en  in  1  global stall; 0 freezes all state.
- valid  out  1  iteration strobe; connects to the buffer's wen/ren.
- ctrl_vars  out  [DIM] x WIDTH  current loop indices, valid when valid=1.
- done  out  1  high once the full nest has been issued.

Behaviour:
- Reset interface: one clock, clk. Reset is asynchronous and active-high, port rst.
- Reset values: valid=0, done=0, ctrl_vars all 0, state=IDLE, delay and II counters 0.
- FSM states: IDLE, WAIT, RUN, DONE. Encoding comes from the package.
- IDLE: outputs idle. flush=1 -> WAIT, loading delay_cnt=START_DELAY. If START_DELAY=0, go straight to RUN.
- WAIT: delay_cnt decrements each en cycle. At delay_cnt==1 -> RUN with ii_cnt=0.
- RUN:
  - valid=1 exactly in cycles where ii_cnt==0 and en=1.
  - In a valid cycle the indices advance odometer-style. The innermost level increments first. A level reaching EXTENTS[k]-1 wraps to 0 and carries into level k-1.
  - ii_cnt counts 0..II-1 and wraps on each en cycle.
- Last iteration: the valid cycle where every level equals EXTENTS[k]-1. After that cycle, go to DONE with ctrl_vars back at all-zero.
- DONE: done=1 and valid=0 until flush or rst.
- Output timing: valid, ctrl_vars and done are registered (Moore) outputs, with no combinational input-to-output path.
- Latency: flush sampled at edge t gives the first valid in the cycle after edge t+START_DELAY+1 (delay counted in en cycles). Strobes then occur every II en-cycles. Total strobes = product of EXTENTS.
- en=0: all counters and the state freeze. valid is forced 0 in that cycle. ctrl_vars hold.
- flush precedence: flush beats everything except rst. In any state it restarts the schedule: ctrl_vars cleared, done cleared, go to WAIT/RUN as from IDLE. flush and en=0 together still restart; the delay then counts only en cycles.
- A flush during RUN aborts the current pass; the strobe in that cycle is suppressed.
- rst asserted mid-run: immediate return to the reset values. No strobe until the next flush.
- Extent 1 levels: such a level is always at its wrap point, so it never changes and passes carry straight through.
- Arithmetic: index increments are WIDTH-bit unsigned with no overflow, because extents are bounded by the parameter check.
  - Elaboration error if any EXTENTS[k]==0, II==0, or DIM<1.

Decomposition:
- Package clockwork_ctrl_pkg holds:
  - ctrl_state_t, the enum IDLE/WAIT/RUN/DONE;
  - CTRL_WIDTH=16;
  - the ctrl_var_t typedef (logic [CTRL_WIDTH-1:0]);
  - the delay-counter width constant, 32.
- Sub-module loop_level_counter, instantiated DIM times in a generate loop:
  - inputs clk, rst, clr, inc, extent;
  - outputs value and wrap (wrap = inc && value==extent-1);
  - the carry chain is built from the wrap outputs.

Test Plan:
- EXTENTS={1,2,3}, START_DELAY=2, II=1, en=1; flush at cycle 0 -> valid high in cycles 3..8 with ctrl_vars (0,0,0),(0,0,1),(0,0,2),(0,1,0),(0,1,1),(0,1,2). done=1 from cycle 9.
- Same config with II=3 -> 6 strobes at cycles 3,6,9,12,15,18. ctrl_vars sequence unchanged. done rises after cycle 18.
- en held low for cycles 4-5 during RUN (II=1, same nest) -> no valid in 4-5. Strobe at cycle 3 is (0,0,0); (0,0,1) appears at cycle 6; the sequence is otherwise intact and ends 2 cycles late.
- flush re-asserted in the cycle carrying (0,1,0) -> no strobe that cycle. After START_DELAY the sequence restarts at (0,0,0) and all 6 strobes follow.
- rst pulsed mid-RUN asynchronously (between edges) -> valid=0, ctrl_vars=0, done=0 immediately; no strobes until the next flush.
- Default params (1x64x64, delay 0, II 1) -> exactly 4096 strobes on consecutive cycles. The last strobe carries (0,63,63). done=1 on the next cycle.

Source files
------------

// File: rtl/clockwork_ctrl_pkg.sv
// Shared types and widths for the affine loop controller.
//   ctrl_state_t : controller FSM states (IDLE, WAIT, RUN, DONE)
//   CTRL_WIDTH   : default width of each loop index / extent
//   ctrl_var_t   : one loop index at the default width
//   DELAY_WIDTH  : width of the start-delay counter
package clockwork_ctrl_pkg;

  localparam int unsigned CTRL_WIDTH  = 16;
  localparam int unsigned DELAY_WIDTH = 32;

  typedef logic [CTRL_WIDTH-1:0] ctrl_var_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/loop_level_counter.sv
// One level of the loop nest: counts 0..extent-1 and wraps.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear to zero (schedule restart)
//   inc      : advance this level by one
//   extent   : trip count of this level
//   value    : current index (registered)
//   wrap     : combinational carry out, high when inc hits the last index
module loop_level_counter
  import clockwork_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CTRL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] extent,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  // Extent 1 sits permanently at its wrap point, so carries pass straight through.
  assign wrap = inc && (value == extent - WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/affine_loop_controller.sv
// Iteration schedule generator for one compute op: after a start delay,
// walks a rectangular DIM-level loop nest issuing one strobe every II cycles.
//   clk, rst  : clock, async active-high reset
//   flush     : synchronous schedule (re)start
//   en        : global stall, 0 freezes all state
//   valid     : iteration strobe (registered)
//   ctrl_vars : loop indices, index 0 outermost (registered)
//   done      : whole nest issued (registered)
module affine_loop_controller
  import clockwork_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH              = CTRL_WIDTH,
  parameter int unsigned DIM                = 3,
  parameter int unsigned EXTENTS [DIM]      = '{1, 64, 64},
  parameter int unsigned START_DELAY        = 0,
  parameter int unsigned II                 = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      en,
  output logic                      valid,
  output logic [DIM-1:0][WIDTH-1:0] ctrl_vars,
  output logic                      done
);

  localparam int unsigned           II_WIDTH   = 8;
  localparam logic [II_WIDTH-1:0]   II_LAST    = II_WIDTH'(II - 1);
  localparam logic [DELAY_WIDTH-1:0] DELAY_INIT = DELAY_WIDTH'(START_DELAY);

  // Elaboration-time parameter sanity.
  if (DIM < 1) begin : g_bad_dim
    $error("affine_loop_controller: DIM must be >= 1");
  end
  if (II == 0 || II > 255) begin : g_bad_ii
    $error("affine_loop_controller: II must be in 1..255");
  end

  ctrl_state_t                state;
  logic [DELAY_WIDTH-1:0]     delay_cnt;
  logic [II_WIDTH-1:0]        ii_cnt;
  logic [DIM-1:0][WIDTH-1:0]  idx;
  logic [DIM-1:0]             inc;
  logic [DIM-1:0]             wrap;
  logic                       strobe;
  logic                       last;

  // An iteration issues on this edge; flush suppresses it.
  assign strobe = (state == RUN) && (ii_cnt == '0) && en && !flush;
  // Every level wrapping at once means the final iteration of the nest.
  assign last   = wrap[0];

  // Odometer: innermost level steps on the strobe, outer levels on inner carry.
  for (genvar k = 0; k < DIM; k++) begin : g_level
    if (EXTENTS[k] == 0 || 64'(EXTENTS[k]) >= (64'(1) << WIDTH)) begin : g_bad_extent
      $error("affine_loop_controller: EXTENTS[%0d] out of range", k);
    end

    if (k == DIM - 1) begin : g_inner
      assign inc[k] = strobe;
    end else begin : g_outer
      assign inc[k] = wrap[k+1];
    end

    loop_level_counter #(
      .WIDTH (WIDTH)
    ) u_level (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .inc    (inc[k]),
      .extent (WIDTH'(EXTENTS[k])),
      .value  (idx[k]),
      .wrap   (wrap[k])
    );
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      delay_cnt <= '0;
      ii_cnt    <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      ctrl_vars <= '0;
    end else if (flush) begin
      valid     <= 1'b0;
      done      <= 1'b0;
      ctrl_vars <= '0;
      ii_cnt    <= '0;
      delay_cnt <= DELAY_INIT;
      state     <= (DELAY_INIT == '0) ? RUN : WAIT;
    end else if (en) begin
      valid <= 1'b0;
      case (state)
        IDLE: ;
        WAIT: begin
          if (delay_cnt == DELAY_WIDTH'(1)) begin
            state  <= RUN;
            ii_cnt <= '0;
          end else begin
            delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
          end
        end
        RUN: begin
          if (ii_cnt == '0) begin
            valid     <= 1'b1;
            ctrl_vars <= idx;
            if (last) begin
              state <= DONE;
            end
          end
          ii_cnt <= (ii_cnt == II_LAST) ? '0 : ii_cnt + II_WIDTH'(1);
        end
        DONE: begin
          done      <= 1'b1;
          ctrl_vars <= '0;
        end
        default: state <= IDLE;
      endcase
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_affine_loop_controller.sv
// Self-checking bench for affine_loop_controller: three instances
// ({1,2,3} II=1 delay 2; {1,2,3} II=3 delay 2; defaults) share stimulus,
// each scenario checks one instance against a queue of expected strobes.
module tb_affine_loop_controller;

  typedef struct packed {
    int               cyc;
    logic [2:0][15:0] vars;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             en;
  logic             va, vb, vc;
  logic             da, db, dc;
  logic [2:0][15:0] ca, cb, cc;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  affine_loop_controller #(
    .WIDTH(16), .DIM(3), .EXTENTS('{1, 2, 3}), .START_DELAY(2), .II(1)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .en(en),
    .valid(va), .ctrl_vars(ca), .done(da)
  );

  affine_loop_controller #(
    .WIDTH(16), .DIM(3), .EXTENTS('{1, 2, 3}), .START_DELAY(2), .II(3)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .en(en),
    .valid(vb), .ctrl_vars(cb), .done(db)
  );

  affine_loop_controller dut_c (
    .clk(clk), .rst(rst), .flush(flush), .en(en),
    .valid(vc), .ctrl_vars(cc), .done(dc)
  );

  task automatic push_exp(input int cyc, input int v1, input int v2);
    exp_t e;
    e.cyc  = cyc;
    e.vars = {16'(v2), 16'(v1), 16'd0};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; en = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (va !== 1'b0 || vb !== 1'b0 || vc !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b%b want=000", va, vb, vc); end
    total++; if (da !== 1'b0 || db !== 1'b0 || dc !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b%b want=000", da, db, dc); end
    total++; if (ca !== '0 || cb !== '0 || cc !== '0) begin bad++; $display("FAIL reset_vars got=%h %h %h want=0", ca, cb, cc); end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (va !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b want=0", c, va); end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    logic want_done;
    sb.delete();
    for (int i = 0; i < 6; i++) push_exp(3 + i, i / 3, i % 3);
    @(negedge clk); flush = 1'b1; en = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      if (va) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL basic_extra cyc=%0d vars=%h", c, ca); end
        else begin
          e = sb.pop_front();
          if (c !== e.cyc || ca !== e.vars) begin bad++; $display("FAIL basic_strobe cyc=%0d vars=%h want cyc=%0d vars=%h", c, ca, e.cyc, e.vars); end
        end
      end
      want_done = (c >= 9);
      total++; if (da !== want_done) begin bad++; $display("FAIL basic_done cyc=%0d got=%b want=%b", c, da, want_done); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_missing left=%0d want=0", sb.size()); end
  endtask

  task automatic test_ii3();
    exp_t e;
    logic want_done;
    sb.delete();
    for (int i = 0; i < 6; i++) push_exp(3 + 3 * i, i / 3, i % 3);
    @(negedge clk); flush = 1'b1; en = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      if (vb) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL ii3_extra cyc=%0d vars=%h", c, cb); end
        else begin
          e = sb.pop_front();
          if (c !== e.cyc || cb !== e.vars) begin bad++; $display("FAIL ii3_strobe cyc=%0d vars=%h want cyc=%0d vars=%h", c, cb, e.cyc, e.vars); end
        end
      end
      want_done = (c >= 19);
      total++; if (db !== want_done) begin bad++; $display("FAIL ii3_done cyc=%0d got=%b want=%b", c, db, want_done); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL ii3_missing left=%0d want=0", sb.size()); end
  endtask

  task automatic test_stall();
    exp_t e;
    logic want_done;
    int   slots [6] = '{3, 6, 7, 8, 9, 10};
    sb.delete();
    for (int i = 0; i < 6; i++) push_exp(slots[i], i / 3, i % 3);
    @(negedge clk); flush = 1'b1; en = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      en = !((c + 1) == 4 || (c + 1) == 5);
      if (va) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stall_extra cyc=%0d vars=%h", c, ca); end
        else begin
          e = sb.pop_front();
          if (c !== e.cyc || ca !== e.vars) begin bad++; $display("FAIL stall_strobe cyc=%0d vars=%h want cyc=%0d vars=%h", c, ca, e.cyc, e.vars); end
        end
      end
      want_done = (c >= 11);
      total++; if (da !== want_done) begin bad++; $display("FAIL stall_done cyc=%0d got=%b want=%b", c, da, want_done); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_missing left=%0d want=0", sb.size()); end
    en = 1'b1;
  endtask

  task automatic test_flush_abort();
    exp_t e;
    logic want_done;
    sb.delete();
    for (int i = 0; i < 3; i++) push_exp(3 + i, 0, i);
    for (int i = 0; i < 6; i++) push_exp(9 + i, i / 3, i % 3);
    @(negedge clk); flush = 1'b1; en = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(posedge clk); @(negedge clk);
      flush = ((c + 1) == 6);
      if (va) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL abort_extra cyc=%0d vars=%h", c, ca); end
        else begin
          e = sb.pop_front();
          if (c !== e.cyc || ca !== e.vars) begin bad++; $display("FAIL abort_strobe cyc=%0d vars=%h want cyc=%0d vars=%h", c, ca, e.cyc, e.vars); end
        end
      end
      want_done = (c >= 15);
      total++; if (da !== want_done) begin bad++; $display("FAIL abort_done cyc=%0d got=%b want=%b", c, da, want_done); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL abort_missing left=%0d want=0", sb.size()); end
    flush = 1'b0;
  endtask

  task automatic test_rst_mid();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 3; i++) push_exp(3 + i, 0, i);
    @(negedge clk); flush = 1'b1; en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      if (va) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rstmid_extra cyc=%0d vars=%h", c, ca); end
        else begin
          e = sb.pop_front();
          if (c !== e.cyc || ca !== e.vars) begin bad++; $display("FAIL rstmid_strobe cyc=%0d vars=%h want cyc=%0d vars=%h", c, ca, e.cyc, e.vars); end
        end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rstmid_missing left=%0d want=0", sb.size()); end
    total++; if (va !== 1'b1) begin bad++; $display("FAIL rstmid_running got=%b want=1", va); end
    rst = 1'b1;
    #1;
    total++; if (va !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", va); end
    total++; if (ca !== '0) begin bad++; $display("FAIL rstmid_vars got=%h want=0", ca); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", da); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (va !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL rstmid_quiet cyc=%0d valid=%b done=%b want=0 0", c, va, da); end
    end
  endtask

  task automatic test_default();
    exp_t e;
    logic want_done;
    sb.delete();
    for (int i = 0; i < 4096; i++) push_exp(1 + i, i / 64, i % 64);
    @(negedge clk); flush = 1'b1; en = 1'b1;
    for (int c = 0; c <= 4100; c++) begin
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      if (vc) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL default_extra cyc=%0d vars=%h", c, cc); end
        else begin
          e = sb.pop_front();
          if (c !== e.cyc || cc !== e.vars) begin bad++; $display("FAIL default_strobe cyc=%0d vars=%h want cyc=%0d vars=%h", c, cc, e.cyc, e.vars); end
        end
      end
      if (c >= 4095) begin
        want_done = (c >= 4097);
        total++; if (dc !== want_done) begin bad++; $display("FAIL default_done cyc=%0d got=%b want=%b", c, dc, want_done); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL default_missing left=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ii3();
    test_stall();
    test_flush_abort();
    test_rst_mid();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
